// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-block instruction cache with same-cycle hit and blocking miss fill.
// Optional hit/miss counters are compiled in when ICACHE_STATS_EN is defined.
module icache_direct #(
  parameter int unsigned SETS          = 16,
  parameter logic [31:0] RESET_PC_WORD = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        flush,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
`ifdef ICACHE_STATS_EN
  output logic [31:0] hit_count,
  output logic [31:0] miss_count,
`endif
  input  logic        iwait,
  input  logic [31:0] iload
);

  localparam int unsigned IDXW = $clog2(SETS);
  localparam int unsigned TAGW = 30 - IDXW;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] FETCH = 1'b1;

  logic [0:0]      state, next_state;
  logic [31:0]     miss_addr;
  logic [SETS-1:0] valid;
  logic [TAGW-1:0] tag_mem  [SETS];
  logic [31:0]     data_mem [SETS];

  logic [IDXW-1:0] req_idx, fill_idx;
  logic [TAGW-1:0] req_tag, fill_tag;
  logic            hit, fill_en, latch_miss;

  assign req_idx  = imemaddr[1+IDXW:2];
  assign req_tag  = imemaddr[31:2+IDXW];
  assign fill_idx = miss_addr[1+IDXW:2];
  assign fill_tag = miss_addr[31:2+IDXW];
  assign hit      = imemREN & valid[req_idx] & (tag_mem[req_idx] == req_tag);

  // Next-state and output decode; hit path is combinational for same-cycle delivery.
  always_comb begin
    next_state = state;
    ihit       = 1'b0;
    imemload   = 32'h0;
    iREN       = 1'b0;
    iaddr      = RESET_PC_WORD;
    fill_en    = 1'b0;
    latch_miss = 1'b0;
    case (state)
      IDLE: begin
        if (hit) begin
          ihit     = 1'b1;
          imemload = data_mem[req_idx];
        end else if (imemREN) begin
          latch_miss = 1'b1;
          next_state = FETCH;
        end
      end
      FETCH: begin
        iREN  = 1'b1;
        iaddr = miss_addr;
        if (!iwait) begin
          fill_en    = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
    if (flush) begin
      next_state = IDLE;
      fill_en    = 1'b0;
    end
    if (RST) begin
      ihit     = 1'b0;
      imemload = 32'h0;
      iREN     = 1'b0;
      iaddr    = RESET_PC_WORD;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      miss_addr <= 32'h0;
      valid     <= '0;
    end else begin
      state <= next_state;
      if (latch_miss) miss_addr <= {imemaddr[31:2], 2'b00};
      if (flush) begin
        valid <= '0;
      end else if (fill_en) begin
        valid[fill_idx] <= 1'b1;
      end
    end
  end

  // Line payload needs no reset; valid bits gate every read.
  always_ff @(posedge CLK) begin
    if (!RST && fill_en) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= iload;
    end
  end

`ifdef ICACHE_STATS_EN
  // Saturating event counters, cleared only by reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hit_count  <= 32'h0;
      miss_count <= 32'h0;
    end else begin
      if (ihit && hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
      if (state == IDLE && next_state == FETCH && miss_count != 32'hFFFF_FFFF)
        miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Directed self-checking bench for icache_direct: cold miss, hit, eviction, branch, flush cases.
module tb_icache_direct;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic        CLK = 1'b0;
  logic        RST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        flush;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  icache_direct #(.SETS(16), .RESET_PC_WORD(RST_PC)) dut (
    .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr), .flush(flush),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
`ifdef ICACHE_STATS_EN
    .hit_count(hit_count), .miss_count(miss_count),
`endif
    .iwait(iwait), .iload(iload)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled mid-cycle.
  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  initial begin
    RST = 1'b1; imemREN = 1'b0; imemaddr = 32'h0; flush = 1'b0; iwait = 1'b1; iload = 32'h0;
    tick(); tick();
    check("rst_ihit", 32'(ihit), 32'h0);
    check("rst_imemload", imemload, 32'h0);
    check("rst_iren", 32'(iREN), 32'h0);
    check("rst_iaddr", iaddr, RST_PC);
`ifdef ICACHE_STATS_EN
    check("rst_hitcnt", hit_count, 32'h0);
    check("rst_misscnt", miss_count, 32'h0);
`endif
    RST = 1'b0;
    tick();

    // Cold miss on 0x40 with two stall cycles
    imemREN = 1'b1; imemaddr = 32'h40; iwait = 1'b1;
    #1;
    check("cold_detect_ihit", 32'(ihit), 32'h0);
    check("cold_detect_iren", 32'(iREN), 32'h0);
    tick();
    check("cold_f1_iren", 32'(iREN), 32'h1);
    check("cold_f1_iaddr", iaddr, 32'h40);
    check("cold_f1_ihit", 32'(ihit), 32'h0);
    tick();
    check("cold_f2_iren", 32'(iREN), 32'h1);
    check("cold_f2_iaddr", iaddr, 32'h40);
    iwait = 1'b0; iload = 32'h2001_0005;
    #1;
    check("cold_f3_iren", 32'(iREN), 32'h1);
    check("cold_f3_iaddr", iaddr, 32'h40);
    tick();
    iwait = 1'b1; iload = 32'h0;
    #1;
    check("cold_hit_ihit", 32'(ihit), 32'h1);
    check("cold_hit_data", imemload, 32'h2001_0005);
    check("cold_hit_iren", 32'(iREN), 32'h0);
    check("cold_hit_iaddr", iaddr, RST_PC);

    // Warm hit with byte offset, then idle request
    imemaddr = 32'h42;
    #1;
    check("warm_ihit", 32'(ihit), 32'h1);
    check("warm_data", imemload, 32'h2001_0005);
    check("warm_iren", 32'(iREN), 32'h0);
    imemREN = 1'b0;
    #1;
    check("noreq_ihit", 32'(ihit), 32'h0);
    check("noreq_data", imemload, 32'h0);
    tick();
    check("noreq_stay_idle", 32'(iREN), 32'h0);

    // Conflict eviction: 0x440 shares index 0 with 0x40
    imemREN = 1'b1; imemaddr = 32'h440;
    #1;
    check("conf_miss", 32'(ihit), 32'h0);
    tick();
    check("conf_iaddr", iaddr, 32'h440);
    iwait = 1'b0; iload = 32'hAAAA_0440;
    tick();
    iwait = 1'b1;
    #1;
    check("conf_hit", 32'(ihit), 32'h1);
    check("conf_data", imemload, 32'hAAAA_0440);
    imemaddr = 32'h40;
    #1;
    check("conf_evicted", 32'(ihit), 32'h0);
    tick();
    check("conf_refetch_iaddr", iaddr, 32'h40);
    iwait = 1'b0; iload = 32'h2001_0005;
    tick();
    iwait = 1'b1;
    #1;
    check("conf_refill_data", imemload, 32'h2001_0005);

    // Branch mid-miss: latched address held, then new miss
    imemaddr = 32'h80;
    tick();
    imemaddr = 32'h100;
    #1;
    check("br_iaddr_a", iaddr, 32'h80);
    tick();
    check("br_iaddr_b", iaddr, 32'h80);
    check("br_ihit", 32'(ihit), 32'h0);
    iwait = 1'b0; iload = 32'h0000_0080;
    tick();
    iwait = 1'b1;
    #1;
    check("br_new_miss", 32'(ihit), 32'h0);
    check("br_idle_iren", 32'(iREN), 32'h0);
    tick();
    check("br_new_iaddr", iaddr, 32'h100);
    check("br_new_iren", 32'(iREN), 32'h1);
    iwait = 1'b0; iload = 32'h0000_0100;
    tick();
    iwait = 1'b1;
    #1;
    check("br_new_data", imemload, 32'h0000_0100);

    // Flush on the fill cycle: nothing written
    imemaddr = 32'h84;
    tick();
    iwait = 1'b0; iload = 32'hDEAD_0084; flush = 1'b1;
    tick();
    flush = 1'b0; iwait = 1'b1;
    #1;
    check("fl_iren_after", 32'(iREN), 32'h0);
    check("fl_line_invalid", 32'(ihit), 32'h0);
    tick();
    check("fl_refetch_iaddr", iaddr, 32'h84);
    iwait = 1'b0; iload = 32'h1234_0084;
    tick();
    iwait = 1'b1;
    #1;
    check("fl_refill_data", imemload, 32'h1234_0084);

    // Flush coincident with a hit: hit this cycle, invalid afterwards
    flush = 1'b1;
    #1;
    check("flhit_ihit", 32'(ihit), 32'h1);
    tick();
    flush = 1'b0;
    #1;
    check("flhit_after", 32'(ihit), 32'h0);
    imemREN = 1'b0;
    tick();
    check("flhit_idle", 32'(iREN), 32'h0);

`ifdef ICACHE_STATS_EN
    // Counters: miss, hit, hit, miss
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("st_clear_hit", hit_count, 32'h0);
    check("st_clear_miss", miss_count, 32'h0);
    imemREN = 1'b1; imemaddr = 32'h200; iwait = 1'b0; iload = 32'h0000_0200;
    tick();
    tick();
    iwait = 1'b1;
    tick();
    tick();
    imemaddr = 32'h600;
    tick();
    imemREN = 1'b0;
    #1;
    check("st_hit_count", hit_count, 32'd2);
    check("st_miss_count", miss_count, 32'd2);
    iwait = 1'b0;
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("st_rst_hit", hit_count, 32'h0);
    check("st_rst_miss", miss_count, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
